// File: rtl/w_full.sv
// w_full: write-domain pointer and full-flag generator for an asynchronous FIFO.
//
// Synchronizes the read domain's Gray read pointer, advances the binary/Gray write
// pointer on accepted writes, and produces the RAM write address, write strobe and
// a registered full flag that asserts on the same edge as the filling write.
//
// Optional feature: define W_FULL_AFULL_EN to add the registered almost_full output
// (occupancy >= AFULL_THRESH), computed from the synchronized read pointer.
//
// Parameters:
//   ADDR_W       RAM address width; depth is 2**ADDR_W, pointers are ADDR_W+1 bits
//   SYNC_STAGES  flop stages on r_ptr_async (2..4)
//   AFULL_THRESH almost_full occupancy threshold (1..2**ADDR_W)
//
// Ports:
//   clk          write-domain clock, rising edge
//   rst          synchronous active-high reset
//   w_en         write request
//   r_ptr_async  Gray read pointer from the read domain (asynchronous)
//   w_ptr        registered Gray write pointer, to the read domain
//   w_addr       registered binary RAM write address
//   w_inc        combinational accepted-write strobe (RAM write enable)
//   full         registered full flag
//   almost_full  registered almost-full flag (W_FULL_AFULL_EN only)

module w_full #(
  parameter int unsigned ADDR_W       = 3,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W:0]   r_ptr_async,
  output logic [ADDR_W:0]   w_ptr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_inc,
  output logic              full
`ifdef W_FULL_AFULL_EN
  ,
  output logic              almost_full
`endif
);

  // Elaboration-time parameter checks.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gen_bad_sync_stages
    $error("w_full: SYNC_STAGES must be in 2..4");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > (2 ** ADDR_W)) begin : gen_bad_afull_thresh
    $error("w_full: AFULL_THRESH must be in 1..2**ADDR_W");
  end
  if (ADDR_W < 2) begin : gen_bad_addr_w
    $error("w_full: ADDR_W must be at least 2");
  end

  logic [ADDR_W:0]   wbin_q, wbin_d;
  logic [ADDR_W:0]   wptr_q, wgray_d;
  logic [ADDR_W-1:0] waddr_q;
  logic              full_q, full_d;
  logic [ADDR_W:0]   rq_q [SYNC_STAGES];
  logic [ADDR_W:0]   rq_sync;
  logic [ADDR_W:0]   rq_full_cmp;

  // Reset gates the strobe so the RAM never sees a write during reset.
  assign w_inc = w_en & ~full_q & ~rst;

  always_comb begin
    wbin_d  = wbin_q + {{ADDR_W{1'b0}}, w_inc};
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    rq_sync = rq_q[SYNC_STAGES-1];
    // Full when the write pointer is one lap ahead: in Gray code that is the read
    // pointer with its top two bits inverted.
    rq_full_cmp = {~rq_sync[ADDR_W -: 2], rq_sync[ADDR_W-2:0]};
    full_d      = (wgray_d == rq_full_cmp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      waddr_q <= '0;
      full_q  <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rq_q[i] <= '0;
      end
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wgray_d;
      waddr_q <= wbin_d[ADDR_W-1:0];
      full_q  <= full_d;
      rq_q[0] <= r_ptr_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rq_q[i] <= rq_q[i-1];
      end
    end
  end

  assign w_ptr  = wptr_q;
  assign w_addr = waddr_q;
  assign full   = full_q;

`ifdef W_FULL_AFULL_EN
  localparam logic [ADDR_W:0] AfThresh = (ADDR_W + 1)'(AFULL_THRESH);

  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] used;
  logic            af_q, af_d;

  always_comb begin
    rbin = '0;
    // Binary bit i is the XOR of Gray bits i and above.
    for (int i = 0; i <= int'(ADDR_W); i++) begin
      rbin[i] = ^(rq_sync >> i);
    end
    used = wbin_d - rbin;
    af_d = (used >= AfThresh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_d;
    end
  end

  assign almost_full = af_q;
`endif

endmodule

// File: tb/tb_w_full.sv
module tb_w_full;

  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_en = 1'b0;
  logic [AW:0]   r_ptr_async = '0;
  logic [AW:0]   w_ptr;
  logic [AW-1:0] w_addr;
  logic          w_inc;
  logic          full;
`ifdef W_FULL_AFULL_EN
  logic          almost_full;
`endif

  always #5 clk = ~clk;

  w_full #(
    .ADDR_W      (AW),
    .SYNC_STAGES (2),
    .AFULL_THRESH(6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .w_en       (w_en),
    .r_ptr_async(r_ptr_async),
    .w_ptr      (w_ptr),
    .w_addr     (w_addr),
    .w_inc      (w_inc),
    .full       (full)
`ifdef W_FULL_AFULL_EN
    ,
    .almost_full(almost_full)
`endif
  );

  // Hand-written 4-bit Gray sequence, index = binary count.
  logic [3:0] gray_tbl [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  typedef struct {
    string      name;
    bit         is_inc;
    logic       inc;
    logic [3:0] ptr;
    logic [2:0] addr;
    logic       full;
    logic       af;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: drains every expectation queued since the last falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   ok;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if (e.is_inc) begin
        if (w_inc !== e.inc) begin
          n_fail++;
          $display("FAIL %s w_inc: got %b want %b", e.name, w_inc, e.inc);
        end
      end else begin
        ok = (w_ptr === e.ptr) && (w_addr === e.addr) && (full === e.full);
`ifdef W_FULL_AFULL_EN
        ok = ok && (almost_full === e.af);
        if (!ok) begin
          n_fail++;
          $display("FAIL %s: got ptr=%b addr=%b full=%b af=%b want ptr=%b addr=%b full=%b af=%b",
                   e.name, w_ptr, w_addr, full, almost_full, e.ptr, e.addr, e.full, e.af);
        end
`else
        if (!ok) begin
          n_fail++;
          $display("FAIL %s: got ptr=%b addr=%b full=%b want ptr=%b addr=%b full=%b",
                   e.name, w_ptr, w_addr, full, e.ptr, e.addr, e.full);
        end
`endif
      end
    end
  end

  // Apply inputs for one edge; queue the w_inc expected for these inputs, then the
  // registered outputs expected after the edge.
  task automatic step(input string name, input logic r, input logic we,
                      input logic [3:0] rp, input logic ei, input logic [3:0] ep,
                      input logic [2:0] ea, input logic ef, input logic eaf);
    exp_t e;
    rst         = r;
    w_en        = we;
    r_ptr_async = rp;
    e.name   = name;
    e.is_inc = 1'b1;
    e.inc    = ei;
    e.ptr    = '0;
    e.addr   = '0;
    e.full   = 1'b0;
    e.af     = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e.is_inc = 1'b0;
    e.ptr    = ep;
    e.addr   = ea;
    e.full   = ef;
    e.af     = eaf;
    sb.push_back(e);
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Reset held for two edges with w_en high.
    for (int i = 0; i < 2; i++) step("reset", 1, 1, 4'b0000, 0, 4'b0000, 3'd0, 0, 0);

    // Fill with the read pointer parked at zero.
    for (int k = 1; k <= 8; k++)
      step("fill", 0, 1, 4'b0000, 1, gray_tbl[k], 3'(k % 8), k == 8, k >= 6);

    // Write while full is dropped.
    step("write_full", 0, 1, 4'b0000, 0, 4'b1100, 3'd0, 1, 1);

    // Release: full clears on the third edge after the read pointer moves.
    for (int i = 0; i < 3; i++)
      step("release", 0, 0, 4'b0001, 0, 4'b1100, 3'd0, i < 2, 1);
    step("refill", 0, 1, 4'b0001, 1, 4'b1101, 3'd1, 1, 1);

    // Wrap with the read pointer tracking the write pointer.
    step("rst_wrap", 1, 1, 4'b0000, 0, 4'b0000, 3'd0, 0, 0);
    for (int k = 1; k <= 16; k++)
      step("wrap", 0, 1, gray_tbl[k-1], 1, gray_tbl[k % 16], 3'(k % 8), 0, 0);

    // Reset in mid-operation.
    for (int k = 1; k <= 5; k++)
      step("pre_rst", 0, 1, 4'b0000, 1, gray_tbl[k], 3'(k), 0, 0);
    step("rst_mid", 1, 1, 4'b0000, 0, 4'b0000, 3'd0, 0, 0);
    step("post_rst", 0, 1, 4'b0000, 1, 4'b0001, 3'd1, 0, 0);

    // Almost-full rises on the sixth accepted write, then clears after read advance.
    for (int k = 2; k <= 6; k++)
      step("afull_rise", 0, 1, 4'b0000, 1, gray_tbl[k], 3'(k), 0, k >= 6);
    for (int i = 0; i < 3; i++)
      step("afull_fall", 0, 0, 4'b0011, 0, 4'b0101, 3'd6, 0, i < 2);

    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/w_full.md
# w_full

Write-side pointer and full-flag generator for the asynchronous FIFO, running entirely in the write clock domain. It synchronizes the read domain's Gray-coded read pointer, advances the write pointer on accepted writes, and produces the RAM write address, write strobe and registered full flag. It sits directly upstream of the read-side empty logic: its Gray write pointer `w_ptr` is the value that logic compares against after crossing into the read domain.

## Interface
- `ADDR_W`, 3: RAM address width; FIFO depth is 2^ADDR_W and pointers are ADDR_W+1 bits.
- `SYNC_STAGES`, 2: flop stages on the incoming read pointer; legal range 2 to 4.
- `AFULL_THRESH`, 6: occupancy at or above which `almost_full` asserts; legal range 1 to 2^ADDR_W.
- `clk`, input, 1: write-domain clock. All logic is on its rising edge.
- `rst`, input, 1: reset. One clock; reset is synchronous and active-high.
- `w_en`, input, 1: write request.
- `r_ptr_async`, input, ADDR_W+1: Gray read pointer from the read domain, asynchronous to `clk`.
- `w_ptr`, output, ADDR_W+1: registered Gray write pointer, sent to the read domain.
- `w_addr`, output, ADDR_W: registered binary RAM write address. Equals the low bits of the binary write count.
- `w_inc`, output, 1: combinational accepted-write strobe, `w_en & ~full`. Drives the RAM write enable.
- `full`, output, 1: registered full flag.
- `almost_full`, output, 1: registered; present only under `W_FULL_AFULL_EN`.

## Operation
- Internal registers: binary count `wbin` (ADDR_W+1 bits), `w_ptr`, `full`, sync chain `rq[SYNC_STAGES]`, and `almost_full` when enabled.
- Next-state values:
  - `wbin_next = wbin + w_inc`, modulo 2^(ADDR_W+1).
  - `wgray_next = (wbin_next >> 1) ^ wbin_next`.
- On each edge:
  - `wbin` loads `wbin_next`.
  - `w_ptr` loads `wgray_next`.
  - `w_addr` loads `wbin_next[ADDR_W-1:0]`.
- Full detection: `full` loads 1 iff `wgray_next` equals the synchronized read pointer with its top two bits inverted and the remaining bits unchanged.
- Write while full: `w_inc` is 0, so pointers hold and the write is dropped. No error flag is raised.
- Wrap-around: the ADDR_W+1-bit pointer wraps naturally (Gray 1000 -> 0000 for ADDR_W=3). `w_addr` wraps every 2^ADDR_W accepted writes.
- Sync chain: shifts `r_ptr_async` in every cycle. Only the last stage is used by any logic.
- Reset, with priority over `w_en`, including mid-operation: on the edge `rst` is sampled high:
  - `wbin`, `w_ptr`, `w_addr`, all sync stages, `full` and `almost_full` all go to 0.
  - `w_inc` reads 0 while `rst` is high.

## Timing
- Accepted write at edge N: `w_ptr` and `w_addr` update at edge N. No extra latency.
- Filling write: `full` asserts at the same edge as the write that fills the FIFO. There is never a cycle where `full=0` with the FIFO already full.
- Release: after `r_ptr_async` changes, `full` deasserts at the (SYNC_STAGES+1)th edge, provided `r_ptr_async` is stable for that whole window. Full release is pessimistic, never early.
- `w_inc` responds combinationally to `full`. The cycle `full` drops, a held `w_en` is accepted.

## Configuration
- `W_FULL_AFULL_EN` defined:
  - Synchronized `rq` is Gray-to-binary converted to `rbin`.
  - `used = wbin_next - rbin`, computed in ADDR_W+1 bits modulo.
  - `almost_full` registers `used >= AFULL_THRESH`. It has the same latency as `full` and resets to 0.
- Not defined: the `almost_full` port, the converter and the subtractor are absent. All other behaviour is identical.

## Test plan
All scenarios use ADDR_W=3 and SYNC_STAGES=2.
- Reset: `rst=1` for 2 edges with `w_en=1` -> `w_ptr=0000`, `w_addr=000`, `full=0`, `w_inc=0`.
- Fill: `w_en=1`, `r_ptr_async=0000` held. After 8 edges -> `w_ptr=1100`, `w_addr=000`, `full=1` at the 8th edge. At the 9th edge `w_inc=0` and `w_ptr` stays 1100.
- Release: from full with `w_en=0`, set `r_ptr_async=0001` -> `full` stays 1 for 2 edges and clears at the 3rd. Then assert `w_en=1` -> one write, `w_ptr=1101`, `full=1` at that edge.
- Wrap: 16 writes with `r_ptr_async` tracking `w_ptr` -> `full` never asserts, and `w_ptr` sequence ends 1000 -> 0000.
- Reset mid-operation: after 5 writes (`w_ptr=0111`), pulse `rst=1` for one edge with `w_en=1` -> all outputs 0. The next write gives `w_ptr=0001`.
- With `W_FULL_AFULL_EN` and `r_ptr_async=0000`: `almost_full` rises at the 6th accepted write. Then set `r_ptr_async=0011` (binary 2) -> `almost_full` clears at the 3rd edge.
